// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master.
//   - command codes presented on cmd[1:0]
//   - FSM state encoding
//   - ADXL345 bus address
//   - quarter_lines(): open-drain pull-down enables {scl_oe, sda_oe} for a
//     given state / quarter / bit position
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WRITE,
    ST_READ,
    ST_STOP,
    ST_REJECT
  } state_e;

  localparam logic [6:0] ADXL_ADDR = 7'h53;

  // Returns {scl_oe, sda_oe} for quarter q of the given state.
  // ack_bit: 9th bit of a byte transfer; dbit: current WRITE data bit.
  function automatic logic [1:0] quarter_lines(
    input state_e     st,
    input logic [1:0] q,
    input logic       ack_bit,
    input logic       dbit,
    input logic       rd_ack
  );
    logic scl_low;
    scl_low = (q == 2'd0) || (q == 2'd3);
    case (st)
      // SDA falls in q2 while SCL is high
      ST_START: case (q)
        2'd0:    quarter_lines = 2'b10;
        2'd1:    quarter_lines = 2'b00;
        2'd2:    quarter_lines = 2'b01;
        default: quarter_lines = 2'b11;
      endcase
      // SDA rises in q2 while SCL is high
      ST_STOP: case (q)
        2'd0:    quarter_lines = 2'b11;
        2'd1:    quarter_lines = 2'b01;
        default: quarter_lines = 2'b00;
      endcase
      ST_WRITE: quarter_lines = {scl_low, ack_bit ? 1'b0   : ~dbit};
      ST_READ:  quarter_lines = {scl_low, ack_bit ? rd_ack : 1'b0};
      default:  quarter_lines = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider.
//   CLOCK_50 : system clock
//   reset    : async active-high
//   run      : count while high
//   clear    : hold counter at 0 (takes priority over run)
//   tick     : one-cycle pulse on the last cycle of each quarter
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == W'(CLK_DIV - 1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run)   cnt <= tick ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: executes one START / WRITE / READ / STOP command at
// a time and returns one response per command.
//   CLOCK_50, reset        : clock, async active-high reset
//   cmd_valid/cmd_ready    : command handshake (ready only in IDLE)
//   cmd, wr_data, rd_ack   : command code, WRITE byte, READ ack to send
//   rsp_valid, err         : completion pulse, 1 = command rejected
//   rd_data, ack_rx        : last READ byte, last WRITE slave ack
//   busy                   : ~cmd_ready
//   scl_oe, sda_oe         : 1 = pull the line low
//   sda_i                  : SDA pin level (asynchronous)
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 125
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       rd_ack,
  output logic       rsp_valid,
  output logic [7:0] rd_data,
  output logic       ack_rx,
  output logic       err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i
);

  state_e     state, state_n;
  logic       tick, run, last, accept, byte_st;
  logic [1:0] q;
  logic [3:0] bit_cnt;
  logic [7:0] tx_sh, rx_sh;
  logic       rd_ack_q;
  logic       bus_active;
  logic [1:0] sda_sync;
  logic       sda_s;

  logic [1:0] nq;
  logic [3:0] nbit;
  logic       ndbit;
  logic [1:0] nxt_lines, acc_lines;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign sda_s     = sda_sync[1];
  assign byte_st   = (state == ST_WRITE) || (state == ST_READ);
  assign run       = (state == ST_START) || (state == ST_STOP) || byte_st;
  assign last      = tick && (q == 2'd3) && (!byte_st || bit_cnt == 4'd8);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .run      (run),
    .clear    (state == ST_IDLE),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state and response strobes. rsp_valid is asserted on the final
  // cycle of the command, while cmd_ready is still low.
  always_comb begin
    state_n   = state;
    rsp_valid = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: if (accept) begin
        case (cmd)
          CMD_START: state_n = ST_START;
          CMD_WRITE: state_n = bus_active ? ST_WRITE : ST_REJECT;
          CMD_READ:  state_n = bus_active ? ST_READ  : ST_REJECT;
          default:   state_n = bus_active ? ST_STOP  : ST_REJECT;
        endcase
      end
      ST_REJECT: begin
        state_n   = ST_IDLE;
        rsp_valid = 1'b1;
        err       = 1'b1;
      end
      ST_START, ST_WRITE, ST_READ, ST_STOP: if (last) begin
        state_n   = ST_IDLE;
        rsp_valid = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line levels for the quarter that begins after the next tick, and for
  // q0 of a freshly accepted command. The outputs are registered so the
  // async clear releases both lines immediately.
  always_comb begin
    nq        = q + 2'd1;
    nbit      = (q == 2'd3) ? bit_cnt + 4'd1 : bit_cnt;
    ndbit     = (q == 2'd3) ? tx_sh[6] : tx_sh[7];
    nxt_lines = quarter_lines(state, nq, nbit == 4'd8, ndbit, rd_ack_q);
    acc_lines = quarter_lines(state_n, 2'd0, 1'b0, wr_data[7], rd_ack);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sda_sync   <= 2'b11;
      q          <= '0;
      bit_cnt    <= '0;
      tx_sh      <= '0;
      rx_sh      <= '0;
      rd_ack_q   <= 1'b0;
      rd_data    <= '0;
      ack_rx     <= 1'b0;
      bus_active <= 1'b0;
      scl_oe     <= 1'b0;
      sda_oe     <= 1'b0;
    end else begin
      sda_sync <= {sda_sync[0], sda_i};
      if (accept) begin
        q        <= '0;
        bit_cnt  <= '0;
        tx_sh    <= wr_data;
        rd_ack_q <= rd_ack;
        // a rejected command leaves the lines untouched
        if (state_n != ST_REJECT) {scl_oe, sda_oe} <= acc_lines;
      end else if (tick) begin
        // sample point: last cycle of q1 (SCL high)
        if (q == 2'd1) begin
          if (state == ST_WRITE && bit_cnt == 4'd8) ack_rx <= ~sda_s;
          if (state == ST_READ) begin
            if (bit_cnt != 4'd8) rx_sh   <= {rx_sh[6:0], sda_s};
            else                 rd_data <= rx_sh;
          end
        end
        if (last) begin
          // q3 levels already hold the correct idle state for each command
          if (state == ST_START) bus_active <= 1'b1;
          if (state == ST_STOP)  bus_active <= 1'b0;
        end else begin
          q <= nq;
          if (q == 2'd3) begin
            bit_cnt <= nbit;
            tx_sh   <= {tx_sh[6:0], 1'b0};
          end
          {scl_oe, sda_oe} <= nxt_lines;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with CLK_DIV=4 and an open-drain slave.
// Stimulus pushes the expected response into a scoreboard queue; a separate
// monitor pops and compares on every rsp_valid.
module tb_i2c_byte_master;
  import i2c_pkg::*;

  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_ack = 1'b0;
  logic       cmd_ready, rsp_valid, ack_rx, err, busy, scl_oe, sda_oe;
  logic [7:0] rd_data;
  logic       sda_i;
  logic       slv_pull = 1'b0;
  logic       scl_line;

  assign scl_line = ~scl_oe;
  assign sda_i    = ~(sda_oe | slv_pull);

  i2c_byte_master #(.CLK_DIV(D)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .wr_data   (wr_data),
    .rd_ack    (rd_ack),
    .rsp_valid (rsp_valid),
    .rd_data   (rd_data),
    .ack_rx    (ack_rx),
    .err       (err),
    .busy      (busy),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_i     (sda_i)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    bit         err;
    int         lat;
    bit         chk_ack;
    bit         ack;
    bit         chk_rd;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(input string n, input bit e, input int lat,
                              input bit ca, input bit a, input bit cr,
                              input logic [7:0] r);
    exp_t x;
    x.name = n; x.err = e; x.lat = lat;
    x.chk_ack = ca; x.ack = a; x.chk_rd = cr; x.rd = r;
    return x;
  endfunction

  // Monitor: acceptance is seen at the posedge, responses at the negedge.
  int edge_n = 0;
  int acc_edge = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK_50);
      if (cmd_valid && cmd_ready) acc_edge = edge_n;
      edge_n++;
      @(negedge CLOCK_50);
      if (!reset && rsp_valid) begin
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          chk({e.name, "_err"}, err, e.err);
          chk({e.name, "_latency"}, edge_n - acc_edge, e.lat);
          if (e.chk_ack) chk({e.name, "_ack_rx"}, ack_rx, e.ack);
          if (e.chk_rd)  chk({e.name, "_rd_data"}, rd_data, e.rd);
        end
      end
    end
  end

  // SDA must only change while SCL is held low during byte transfers.
  logic in_byte = 1'b0;
  int   glitches = 0;
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (in_byte && sda_oe != prev && !scl_oe) glitches++;
      prev = sda_oe;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLOCK_50);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_scl(input logic lvl);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_50);
      if (scl_line == lvl) begin ok = 1'b1; break; end
    end
    if (!ok) chk("scl_timeout", 0, 1);
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] d, input logic a);
    wait_ready();
    cmd_valid = 1'b1; cmd = c; wr_data = d; rd_ack = a;
    @(posedge CLOCK_50);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [1:0] c, input exp_t e);
    sb.push_back(e);
    send(c, 8'h00, 1'b0);
    wait_ready();
  endtask

  // WRITE/READ with slave emulation. obs collects sda_oe at each SCL high,
  // MSB first: obs[8:1] = data bits, obs[0] = 9th bit.
  task automatic byte_cmd(input logic [1:0] c, input logic [7:0] d, input logic a,
                          input logic [7:0] sbyte, input bit sack, input exp_t e,
                          output logic [8:0] obs);
    obs = '0;
    glitches = 0;
    sb.push_back(e);
    in_byte = 1'b1;
    send(c, d, a);
    for (int i = 0; i < 9; i++) begin
      if (c == CMD_READ && i < 8) slv_pull = ~sbyte[7-i];
      else                        slv_pull = (c == CMD_WRITE && i == 8) ? sack : 1'b0;
      wait_scl(1'b1);
      obs = {obs[7:0], sda_oe};
      wait_scl(1'b0);
    end
    slv_pull = 1'b0;
    wait_ready();
    in_byte = 1'b0;
  endtask

  initial begin
    logic [8:0] obs;
    #5 reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50) reset = 1'b0;
    @(negedge CLOCK_50);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_err", {rsp_valid, err}, 0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_ack_rx", ack_rx, 0);
    chk("rst_lines_high", {scl_line, sda_i}, 2'b11);

    run_cmd(CMD_START, mk("start", 0, 4*D, 0, 0, 0, 0));
    chk("start_lines", {scl_oe, sda_oe}, 2'b11);

    byte_cmd(CMD_WRITE, {ADXL_ADDR, 1'b0}, 1'b0, 8'h00, 1'b1,
             mk("wr_a6", 0, 36*D, 1, 1, 0, 0), obs);
    chk("wr_a6_sda_bits", obs[8:1], 8'h59);
    chk("wr_a6_ack_bit_released", obs[0], 0);
    chk("wr_a6_sda_stable_scl_high", glitches, 0);

    byte_cmd(CMD_WRITE, 8'h3C, 1'b0, 8'h00, 1'b0,
             mk("wr_nack", 0, 36*D, 1, 0, 0, 0), obs);
    chk("wr_nack_sda_bits", obs[8:1], 8'hC3);
    chk("wr_nack_bus_active", scl_oe, 1);

    byte_cmd(CMD_READ, 8'h00, 1'b0, 8'h5A, 1'b0,
             mk("rd_nack", 0, 36*D, 1, 0, 1, 8'h5A), obs);
    chk("rd_nack_sda", obs, 9'h000);
    chk("rd_nack_sda_stable", glitches, 0);

    byte_cmd(CMD_READ, 8'h00, 1'b1, 8'hC3, 1'b0,
             mk("rd_ack", 0, 36*D, 0, 0, 1, 8'hC3), obs);
    chk("rd_ack_sda", obs, 9'h001);

    run_cmd(CMD_START, mk("rstart", 0, 4*D, 0, 0, 0, 0));
    run_cmd(CMD_STOP,  mk("stop", 0, 4*D, 0, 0, 0, 0));
    chk("stop_lines_released", {scl_oe, sda_oe}, 2'b00);

    // commands before START are rejected without touching the bus
    @(negedge CLOCK_50) reset = 1'b1;
    @(negedge CLOCK_50) reset = 1'b0;
    run_cmd(CMD_WRITE, mk("rej_wr", 1, 1, 0, 0, 0, 0));
    chk("rej_wr_lines", {scl_oe, sda_oe}, 2'b00);
    run_cmd(CMD_START, mk("start2", 0, 4*D, 0, 0, 0, 0));
    run_cmd(CMD_STOP,  mk("stop2", 0, 4*D, 0, 0, 0, 0));
    run_cmd(CMD_READ,  mk("rej_rd", 1, 1, 0, 0, 0, 0));
    chk("rej_rd_lines", {scl_oe, sda_oe}, 2'b00);

    // reset during bit 3 of a WRITE
    run_cmd(CMD_START, mk("start3", 0, 4*D, 0, 0, 0, 0));
    send(CMD_WRITE, 8'hA6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_scl(1'b1);
      wait_scl(1'b0);
    end
    repeat (D) @(negedge CLOCK_50);
    chk("bit3_lines", {scl_oe, sda_oe}, 2'b11);
    reset = 1'b1;
    #1;
    chk("midreset_lines", {scl_oe, sda_oe}, 2'b00);
    sb.delete();
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("midreset_ready", cmd_ready, 1);
    run_cmd(CMD_START, mk("start4", 0, 4*D, 0, 0, 0, 0));
    chk("start4_lines", {scl_oe, sda_oe}, 2'b11);
    run_cmd(CMD_STOP, mk("stop4", 0, 4*D, 0, 0, 0, 0));

    repeat (4) @(negedge CLOCK_50);
    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
